// File: rtl/serial_link_defs_pkg.sv
// Shared definitions for the serial parity link (receiver now, transmitter later).
// The state encoding and parity mode constants must match on both ends of the link.
package serial_link_defs_pkg;

    localparam int DEFAULT_DATA_W   = 8;
    localparam int DEFAULT_BAUD_DIV = 16;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } link_state_t;

    // The parity bit a sender must put on the line, given the XOR of all data bits.
    function automatic logic parity_expected(input logic data_xor, input bit odd_mode);
        return data_xor ^ (odd_mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; the reset value is chosen
// to match the idle level of the line being synchronised.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/serial_parity_rx.sv
// Serial parity link receiver: start, DATA_W data bits LSB first, parity, stop.
// Every bit is sampled mid-period; each completed frame produces a one-cycle valid.
module serial_parity_rx
    import serial_link_defs_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter bit PARITY_ODD = PAR_EVEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int IDX_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_W - 1);

    logic              w_rx_s;
    logic              w_tick;
    link_state_t       r_state;
    link_state_t       w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_acc;
    logic              r_par_mismatch;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_parity_err;
    logic              r_frame_err;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

    assign w_tick = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (!w_rx_s) w_next_state = S_START;
            S_START:  if (w_tick) w_next_state = w_rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (w_tick && (r_idx == LAST_IDX)) w_next_state = S_PARITY;
            S_PARITY: if (w_tick) w_next_state = S_STOP;
            S_STOP:   if (w_tick) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // The timer parks at zero on a false start or after the stop bit, so it
    // never wraps; IDLE always reloads it before it is used again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_idx          <= '0;
            r_shift        <= '0;
            r_acc          <= 1'b0;
            r_par_mismatch <= 1'b0;
            r_data         <= '0;
            r_valid        <= 1'b0;
            r_parity_err   <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_cnt <= HALF_RELOAD;
                    end
                end
                S_START: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (!w_rx_s) begin
                        r_cnt <= FULL_RELOAD;
                        r_idx <= '0;
                        r_acc <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_cnt   <= FULL_RELOAD;
                        r_shift <= DATA_W'({w_rx_s, r_shift} >> 1);
                        r_acc   <= r_acc ^ w_rx_s;
                        r_idx   <= r_idx + IDX_W'(1);
                    end
                end
                S_PARITY: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_cnt          <= FULL_RELOAD;
                        r_par_mismatch <= w_rx_s ^ parity_expected(r_acc, PARITY_ODD);
                    end
                end
                S_STOP: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_valid      <= 1'b1;
                        r_data       <= r_shift;
                        r_parity_err <= r_par_mismatch;
                        r_frame_err  <= ~w_rx_s;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign data_out   = r_data;
    assign valid      = r_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
// Self-checking bench for serial_parity_rx: directed frames plus random frames on an
// even-parity receiver, and a zero-gap back-to-back pair on an odd-parity receiver.
module tb_serial_parity_rx;

    localparam int DW  = 8;
    localparam int BD  = 16;
    localparam int LAT = 2 + BD / 2 + (DW + 2) * BD + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rxEven;
    logic          rxOdd;
    logic [DW-1:0] dataEven;
    logic [DW-1:0] dataOdd;
    logic          validEven, validOdd;
    logic          perrEven, perrOdd;
    logic          ferrEven, ferrOdd;
    logic          busyEven, busyOdd;

    int            compared   = 0;
    int            mismatched = 0;
    longint        cyc        = 0;

    int            vCnt [2]   = '{0, 0};
    logic [DW-1:0] vData [2];
    logic          vPerr [2];
    logic          vFerr [2];
    longint        vCyc [2]   = '{0, 0};
    longint        startCyc [2];

    serial_parity_rx #(.DATA_W(DW), .BAUD_DIV(BD), .PARITY_ODD(1'b0)) dutEven (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rxEven),
        .data_out   (dataEven),
        .valid      (validEven),
        .parity_err (perrEven),
        .frame_err  (ferrEven),
        .busy       (busyEven)
    );

    serial_parity_rx #(.DATA_W(DW), .BAUD_DIV(BD), .PARITY_ODD(1'b1)) dutOdd (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rxOdd),
        .data_out   (dataOdd),
        .valid      (validOdd),
        .parity_err (perrOdd),
        .frame_err  (ferrOdd),
        .busy       (busyOdd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every valid pulse with its cycle stamp, one cycle at a time.
    always @(posedge clk) begin
        #1;
        if (validEven === 1'b1) begin
            vCnt[0]  = vCnt[0] + 1;
            vData[0] = dataEven;
            vPerr[0] = perrEven;
            vFerr[0] = ferrEven;
            vCyc[0]  = cyc;
        end
        if (validOdd === 1'b1) begin
            vCnt[1]  = vCnt[1] + 1;
            vData[1] = dataOdd;
            vPerr[1] = perrOdd;
            vFerr[1] = ferrOdd;
            vCyc[1]  = cyc;
        end
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic driveBit(input int sel, input logic b);
        if (sel == 0) rxEven = b;
        else          rxOdd  = b;
        repeat (BD) tick1();
    endtask

    task automatic idleBits(input int sel, input int n);
        for (int i = 0; i < n; i++) driveBit(sel, 1'b1);
    endtask

    task automatic applyStimulus(input int sel, input logic [DW-1:0] data, input logic pbit, input logic stop);
        startCyc[sel] = cyc;
        driveBit(sel, 1'b0);
        for (int i = 0; i < DW; i++) driveBit(sel, data[i]);
        driveBit(sel, pbit);
        driveBit(sel, stop);
    endtask

    // Reference: one valid per frame, data echoed, parity and stop judged from the frame itself.
    task automatic checkFrame(input string tag, input int sel, input logic [DW-1:0] data,
                              input logic pbit, input logic stop, input int prevCnt);
        logic          oddMode;
        logic          expPerr;
        logic [DW-1:0] portData;
        oddMode  = (sel == 1);
        expPerr  = (pbit != ((^data) ^ oddMode));
        portData = (sel == 0) ? dataEven : dataOdd;
        checkOutput({tag, "_count"}, vCnt[sel], prevCnt + 1);
        checkOutput({tag, "_data"}, vData[sel], data);
        checkOutput({tag, "_perr"}, vPerr[sel], expPerr);
        checkOutput({tag, "_ferr"}, vFerr[sel], !stop);
        checkOutput({tag, "_latency"}, vCyc[sel] - startCyc[sel], LAT);
        checkOutput({tag, "_hold"}, portData, data);
    endtask

    initial begin
        int            prev;
        logic          sawBusy;
        longint        firstCyc;
        logic [DW-1:0] rData;
        logic          rPbit;
        logic          rStop;

        rst_n  = 1'b0;
        rxEven = 1'b1;
        rxOdd  = 1'b1;
        repeat (3) tick1();
        checkOutput("rst_data", dataEven, 0);
        checkOutput("rst_valid", validEven, 0);
        checkOutput("rst_perr", perrEven, 0);
        checkOutput("rst_ferr", ferrEven, 0);
        checkOutput("rst_busy", busyEven, 0);
        checkOutput("rst_busy_odd", busyOdd, 0);
        rst_n = 1'b1;
        idleBits(0, 1);

        $display("[TB] good frame 0xA5");
        prev = vCnt[0];
        applyStimulus(0, 8'hA5, 1'b0, 1'b1);
        checkFrame("a5_ok", 0, 8'hA5, 1'b0, 1'b1, prev);
        checkOutput("a5_ok_busy", busyEven, 0);
        idleBits(0, 1);

        $display("[TB] parity error 0xA5");
        prev = vCnt[0];
        applyStimulus(0, 8'hA5, 1'b1, 1'b1);
        checkFrame("a5_perr", 0, 8'hA5, 1'b1, 1'b1, prev);
        idleBits(0, 1);

        $display("[TB] framing error 0x3C");
        prev = vCnt[0];
        applyStimulus(0, 8'h3C, 1'b0, 1'b0);
        checkFrame("3c_ferr", 0, 8'h3C, 1'b0, 1'b0, prev);
        idleBits(0, 2);
        checkOutput("3c_no_extra", vCnt[0], prev + 1);
        checkOutput("3c_busy_after", busyEven, 0);

        $display("[TB] glitch");
        prev    = vCnt[0];
        sawBusy = 1'b0;
        rxEven  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick1();
            if (busyEven === 1'b1) sawBusy = 1'b1;
        end
        rxEven = 1'b1;
        for (int i = 0; i < BD / 2 + 3; i++) begin
            tick1();
            if (busyEven === 1'b1) sawBusy = 1'b1;
        end
        checkOutput("glitch_seen", sawBusy, 1);
        checkOutput("glitch_busy", busyEven, 0);
        checkOutput("glitch_novalid", vCnt[0], prev);
        checkOutput("glitch_hold", dataEven, 8'h3C);
        idleBits(0, 1);

        $display("[TB] reset mid-frame");
        prev = vCnt[0];
        driveBit(0, 1'b0);
        driveBit(0, 1'b1);
        driveBit(0, 1'b0);
        rst_n  = 1'b0;
        rxEven = 1'b1;
        #1;
        checkOutput("abort_busy", busyEven, 0);
        repeat (3) tick1();
        rst_n = 1'b1;
        idleBits(0, 2);
        checkOutput("abort_novalid", vCnt[0], prev);
        checkOutput("abort_data", dataEven, 0);
        applyStimulus(0, 8'h5A, 1'b0, 1'b1);
        checkFrame("5a_after", 0, 8'h5A, 1'b0, 1'b1, prev);
        idleBits(0, 1);

        $display("[TB] odd parity back-to-back");
        prev = vCnt[1];
        applyStimulus(1, 8'h00, 1'b1, 1'b1);
        checkFrame("b2b_00", 1, 8'h00, 1'b1, 1'b1, prev);
        firstCyc = vCyc[1];
        applyStimulus(1, 8'hFF, 1'b1, 1'b1);
        checkFrame("b2b_ff", 1, 8'hFF, 1'b1, 1'b1, prev + 1);
        checkOutput("b2b_spacing", vCyc[1] - firstCyc, 11 * BD);
        idleBits(1, 1);
        checkOutput("b2b_busy", busyOdd, 0);

        $display("[TB] random frames");
        for (int n = 0; n < 12; n++) begin
            rData = DW'($urandom);
            rPbit = (^rData) ^ ($urandom_range(0, 3) == 0);
            rStop = ($urandom_range(0, 3) != 0);
            prev  = vCnt[0];
            applyStimulus(0, rData, rPbit, rStop);
            checkFrame("rand", 0, rData, rPbit, rStop, prev);
            if (rStop) idleBits(0, $urandom_range(0, 2));
            else       idleBits(0, $urandom_range(1, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
